ysyx_lsu_req: RTL and testbench
===============================

Name: ysyx_lsu_req

Overview:
LSU memory-request stage sitting directly upstream of the bus arbiter's lsu load/store ports. It accepts one load or store per handshake from the execute stage and validates alignment. It then drives the arbiter's level-held lsu_ar*/lsu_aw*/lsu_w* request signals until the arbiter responds. Finally it sign/zero-extends load data and returns a tagged result to writeback, with a bus-hang timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 1023, max cycles a bus request stays asserted before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid from execute
req_ready  out  1  stage can accept a request
req_wen  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, unshifted, in low bits
req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_rd  in  5  destination tag, passed through
lsu_araddr  out  ADDR_W  load address to arbiter
lsu_arvalid  out  1  load request, held until lsu_rvalid
lsu_rstrb  out  8  8'h01/8'h03/8'h0f for byte/half/word
lsu_rdata  in  DATA_W  load data, already right-aligned by arbiter
lsu_rvalid  in  1  load data valid
lsu_awaddr  out  ADDR_W  store address
lsu_awvalid  out  1  store address valid
lsu_wdata  out  DATA_W  store data, unshifted
lsu_wstrb  out  8  8'h01/8'h03/8'h0f, unshifted
lsu_wvalid  out  1  store data valid, held until lsu_wready
lsu_wready  in  1  store accepted
rsp_valid  out  1  result valid to writeback
rsp_ready  in  1  writeback accepts result
rsp_wen  out  1  echoed req_wen
rsp_rd  out  5  echoed req_rd
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
rsp_err  out  2  00 ok, 01 misaligned, 10 bus timeout

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; timeout counter 0; all latched fields 0.
- Reset values: all outputs 0 except req_ready=1. Reset mid-transaction drops all valids immediately; the transaction is lost and no response is produced.
- FSM has four states: IDLE, LOAD, STORE, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch addr/wdata/funct3/rd/wen.
  - Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0. This goes to RESP with err=01 and issues no bus request.
  - Unsupported funct3 (011, 110, 111; or 100/101 with req_wen=1) is treated as misaligned (err=01).
  - Otherwise go to LOAD (wen=0) or STORE (wen=1).
- LOAD:
  - lsu_arvalid=1; lsu_araddr and lsu_rstrb are stable from the latch.
  - On lsu_rvalid: extend lsu_rdata per funct3 (B: sign from bit7; H: sign from bit15; BU/HU: zero-extend; W: pass through). Register the result and go to RESP.
  - lsu_arvalid must be 0 in the cycle after lsu_rvalid; the arbiter samples lsu_arvalid registered.
- STORE:
  - lsu_awvalid=lsu_wvalid=1; lsu_awaddr, lsu_wdata and lsu_wstrb are stable.
  - On lsu_wready go to RESP with rdata=0.
- Timeout: the counter increments each cycle in LOAD/STORE and clears on entry. When the count reaches TIMEOUT-1 with no response, drop the request and go to RESP with err=10, rdata=0. If lsu_rvalid/lsu_wready arrives in the same cycle as timeout, the response wins (err=00).
- RESP:
  - rsp_valid=1; rsp_* fields are stable until rsp_ready, then go to IDLE.
  - req_ready=0 in RESP; no bypass to IDLE in the same cycle.
- Latency:
  - Accept at cycle 0; bus request is asserted from cycle 1.
  - Response rsp_valid is asserted the cycle after lsu_rvalid/lsu_wready.
  - Misaligned requests give rsp_valid at cycle 1.
- lsu_araddr/lsu_awaddr always drive the latched address, including when idle.
- Address offset shifting and wstrb lane placement are done by the arbiter; this block never shifts data.
- All bus-side valids are decoded from state registers only (glitch-free). There is no combinational path from lsu_rvalid/lsu_wready to request valids.

Test Plan:
- LB at 0x80000003, arbiter returns lsu_rdata=0x000000F0 after 3 cycles -> lsu_rstrb=0x01, arvalid high 3 cycles then 0, rsp_rdata=0xFFFFFFF0, rsp_err=00, rsp_valid one cycle after rvalid.
- LHU at 0x80000002, lsu_rdata=0xDEAD8001 -> rsp_rdata=0x00008001; same with LH -> 0xFFFF8001.
- SH to 0x80000102, wdata=0x1234ABCD, wready after 2 cycles -> awaddr=0x80000102, wstrb=0x03, wdata=0x1234ABCD, aw/wvalid high 2 cycles, rsp_rdata=0, err=00.
- LW at 0x80000001 -> no arvalid ever, rsp_valid at cycle 1, rsp_err=01.
- TIMEOUT=16, LW with no rvalid -> arvalid high exactly 16 cycles, then rsp_err=10, rsp_rdata=0. Then hold rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0 throughout.
- Assert rst=0 asynchronously mid-LOAD -> arvalid drops without a clock edge, no rsp_valid; after release a new LW completes normally.

Source files
------------

// File: rtl/ysyx_lsu_req_if.sv
// LSU-to-arbiter request bus: level-held load (ar/r) and store (aw/w) channels.
// The master side is the LSU request stage; the slave side is the arbiter.
interface ysyx_lsu_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] lsu_araddr;
    logic              lsu_arvalid;
    logic [7:0]        lsu_rstrb;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_rvalid;
    logic [ADDR_W-1:0] lsu_awaddr;
    logic              lsu_awvalid;
    logic [DATA_W-1:0] lsu_wdata;
    logic [7:0]        lsu_wstrb;
    logic              lsu_wvalid;
    logic              lsu_wready;

    modport master (
        output lsu_araddr, lsu_arvalid, lsu_rstrb,
        input  lsu_rdata, lsu_rvalid,
        output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
        input  lsu_wready
    );

    modport slave (
        input  lsu_araddr, lsu_arvalid, lsu_rstrb,
        output lsu_rdata, lsu_rvalid,
        input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
        output lsu_wready
    );
endinterface

// File: rtl/ysyx_lsu_req.sv
// LSU memory-request stage: alignment check, level-held arbiter request,
// load-data extension and tagged response with bus-hang timeout.
module ysyx_lsu_req #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rd,
    ysyx_lsu_req_if.master    lsu,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wen,
    output logic [4:0]        rsp_rd,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              wen_q;
    logic [7:0]        strb_q;
    logic [1:0]        err_q;

    logic              accept;
    logic              bad;
    logic              timeout;
    logic [7:0]        strb_d;
    logic [DATA_W-1:0] ext_data;

    assign accept  = (state_q == IDLE) && req_valid;
    assign timeout = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Unsupported encodings are folded into the misaligned error.
    always_comb begin
        bad = 1'b1;
        unique case (req_funct3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = req_addr[0];
            3'b010:  bad = |req_addr[1:0];
            3'b100:  bad = req_wen;
            3'b101:  bad = req_wen | req_addr[0];
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        strb_d = 8'h00;
        unique case (1'b1)
            req_funct3[1:0] == 2'b00: strb_d = 8'h01;
            req_funct3[1:0] == 2'b01: strb_d = 8'h03;
            req_funct3[1:0] == 2'b10: strb_d = 8'h0f;
            default:                  strb_d = 8'h00;
        endcase
    end

    always_comb begin
        ext_data = lsu.lsu_rdata;
        unique case (funct3_q)
            3'b000:  ext_data = {{(DATA_W-8){lsu.lsu_rdata[7]}}, lsu.lsu_rdata[7:0]};
            3'b001:  ext_data = {{(DATA_W-16){lsu.lsu_rdata[15]}}, lsu.lsu_rdata[15:0]};
            3'b100:  ext_data = {{(DATA_W-8){1'b0}}, lsu.lsu_rdata[7:0]};
            3'b101:  ext_data = {{(DATA_W-16){1'b0}}, lsu.lsu_rdata[15:0]};
            default: ext_data = lsu.lsu_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Bus valids come from the state register only, never from bus inputs.
    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        lsu.lsu_arvalid = 1'b0;
        lsu.lsu_awvalid = 1'b0;
        lsu.lsu_wvalid  = 1'b0;
        rsp_valid       = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad)          state_d = RESP;
                    else if (req_wen) state_d = STORE;
                    else              state_d = LOAD;
                end
            end
            LOAD: begin
                lsu.lsu_arvalid = 1'b1;
                if (lsu.lsu_rvalid || timeout) state_d = RESP;
            end
            STORE: begin
                lsu.lsu_awvalid = 1'b1;
                lsu.lsu_wvalid  = 1'b1;
                if (lsu.lsu_wready || timeout) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == LOAD || state_q == STORE) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            wen_q    <= 1'b0;
            strb_q   <= '0;
            err_q    <= '0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata_q  <= '0;
                funct3_q <= req_funct3;
                rd_q     <= req_rd;
                wen_q    <= req_wen;
                strb_q   <= strb_d;
                err_q    <= bad ? 2'b01 : 2'b00;
            end
            // A response arriving with the timeout still wins.
            if (state_q == LOAD) begin
                if (lsu.lsu_rvalid) rdata_q <= ext_data;
                else if (timeout)   err_q   <= 2'b10;
            end
            if (state_q == STORE && !lsu.lsu_wready && timeout) begin
                err_q <= 2'b10;
            end
        end
    end

    assign lsu.lsu_araddr = addr_q;
    assign lsu.lsu_rstrb  = strb_q;
    assign lsu.lsu_awaddr = addr_q;
    assign lsu.lsu_wdata  = wdata_q;
    assign lsu.lsu_wstrb  = strb_q;

    assign rsp_wen   = wen_q;
    assign rsp_rd    = rd_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_ysyx_lsu_req.sv
// Directed table-driven bench for ysyx_lsu_req with a small arbiter stub
// driven from the vector table; TIMEOUT is shortened to 16.
module tb_ysyx_lsu_req;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic [4:0]  req_rd = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_wen;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int tests = 0;
    int fails = 0;

    ysyx_lsu_req_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_lsu_req #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .req_rd     (req_rd),
        .lsu        (bus.master),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_wen    (rsp_wen),
        .rsp_rd     (rsp_rd),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        uses_bus;
        int          delay;
        logic [31:0] bdata;
        int          hold;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [7:0]  strb;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(string nm, logic wen, logic [31:0] addr,
                                logic [31:0] wdata, logic [2:0] f3, logic [4:0] rd,
                                logic uses_bus, int delay, logic [31:0] bdata,
                                int hold, logic [1:0] err, logic [31:0] rdata,
                                logic [7:0] strb);
        vec_t v;
        v.name = nm; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.f3 = f3; v.rd = rd; v.uses_bus = uses_bus; v.delay = delay;
        v.bdata = bdata; v.hold = hold; v.err = err; v.rdata = rdata;
        v.strb = strb;
        return v;
    endfunction

    function automatic logic bus_active(logic wen);
        return wen ? (bus.lsu_awvalid & bus.lsu_wvalid) : bus.lsu_arvalid;
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        int exp_n;
        @(negedge clk);
        chk({v.name, ".req_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_wen    = v.wen;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_funct3 = v.f3;
        req_rd     = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        if (v.uses_bus) begin
            exp_n = (v.delay == 0) ? 16 : v.delay;
            while (bus_active(v.wen) && n < 40) begin
                n++;
                if (n == 1) begin
                    if (v.wen) begin
                        chk({v.name, ".awaddr"}, 64'(bus.lsu_awaddr), 64'(v.addr));
                        chk({v.name, ".wdata"}, 64'(bus.lsu_wdata), 64'(v.wdata));
                        chk({v.name, ".wstrb"}, 64'(bus.lsu_wstrb), 64'(v.strb));
                        chk({v.name, ".arvalid"}, 64'(bus.lsu_arvalid), 64'd0);
                    end else begin
                        chk({v.name, ".araddr"}, 64'(bus.lsu_araddr), 64'(v.addr));
                        chk({v.name, ".rstrb"}, 64'(bus.lsu_rstrb), 64'(v.strb));
                        chk({v.name, ".awvalid"}, 64'(bus.lsu_awvalid), 64'd0);
                    end
                end
                chk({v.name, ".rsp_valid_busy"}, 64'(rsp_valid), 64'd0);
                if (n == v.delay) begin
                    bus.lsu_rdata = v.bdata;
                    if (v.wen) bus.lsu_wready = 1'b1;
                    else       bus.lsu_rvalid = 1'b1;
                end
                @(negedge clk);
                bus.lsu_rvalid = 1'b0;
                bus.lsu_wready = 1'b0;
            end
            chk({v.name, ".bus_cycles"}, 64'(n), 64'(exp_n));
        end else begin
            chk({v.name, ".no_bus"}, 64'(bus.lsu_arvalid | bus.lsu_awvalid | bus.lsu_wvalid), 64'd0);
        end
        chk({v.name, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({v.name, ".rsp_err"}, 64'(rsp_err), 64'(v.err));
        chk({v.name, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.rdata));
        chk({v.name, ".rsp_rd"}, 64'(rsp_rd), 64'(v.rd));
        chk({v.name, ".rsp_wen"}, 64'(rsp_wen), 64'(v.wen));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({v.name, ".hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({v.name, ".hold_err"}, 64'(rsp_err), 64'(v.err));
            chk({v.name, ".hold_rdata"}, 64'(rsp_rdata), 64'(v.rdata));
            chk({v.name, ".hold_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({v.name, ".rsp_done"}, 64'(rsp_valid), 64'd0);
        chk({v.name, ".back_idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int n;
        bus.lsu_rdata  = '0;
        bus.lsu_rvalid = 1'b0;
        bus.lsu_wready = 1'b0;

        vt[0]  = mk("lb_neg",   0, 32'h80000003, 0, 3'b000, 5'd1,  1, 3,  32'h000000F0, 0, 2'b00, 32'hFFFFFFF0, 8'h01);
        vt[1]  = mk("lhu",      0, 32'h80000002, 0, 3'b101, 5'd2,  1, 1,  32'hDEAD8001, 0, 2'b00, 32'h00008001, 8'h03);
        vt[2]  = mk("lh",       0, 32'h80000002, 0, 3'b001, 5'd3,  1, 1,  32'hDEAD8001, 0, 2'b00, 32'hFFFF8001, 8'h03);
        vt[3]  = mk("sh",       1, 32'h80000102, 32'h1234ABCD, 3'b001, 5'd4, 1, 2, 0, 0, 2'b00, 32'h0, 8'h03);
        vt[4]  = mk("lw_mis",   0, 32'h80000001, 0, 3'b010, 5'd5,  0, 0,  0, 0, 2'b01, 32'h0, 8'h00);
        vt[5]  = mk("lw_tmo",   0, 32'h80000010, 0, 3'b010, 5'd6,  1, 0,  0, 5, 2'b10, 32'h0, 8'h0f);
        vt[6]  = mk("lbu",      0, 32'h80000005, 0, 3'b100, 5'd7,  1, 1,  32'h123456A5, 0, 2'b00, 32'h000000A5, 8'h01);
        vt[7]  = mk("lw",       0, 32'h80000004, 0, 3'b010, 5'd8,  1, 4,  32'hCAFEBABE, 0, 2'b00, 32'hCAFEBABE, 8'h0f);
        vt[8]  = mk("sw_mis",   1, 32'h80000002, 32'h55, 3'b010, 5'd9, 0, 0, 0, 0, 2'b01, 32'h0, 8'h00);
        vt[9]  = mk("f3_011",   0, 32'h80000000, 0, 3'b011, 5'd10, 0, 0,  0, 0, 2'b01, 32'h0, 8'h00);
        vt[10] = mk("sbu_st",   1, 32'h80000000, 32'h1, 3'b100, 5'd11, 0, 0, 0, 0, 2'b01, 32'h0, 8'h00);
        vt[11] = mk("sb_odd",   1, 32'h80000007, 32'hAB, 3'b000, 5'd12, 1, 1, 0, 0, 2'b00, 32'h0, 8'h01);
        vt[12] = mk("lw_edge",  0, 32'h80000008, 0, 3'b010, 5'd13, 1, 16, 32'h11223344, 0, 2'b00, 32'h11223344, 8'h0f);
        vt[13] = mk("sw_tmo",   1, 32'h8000000C, 32'h77, 3'b010, 5'd14, 1, 0, 0, 1, 2'b10, 32'h0, 8'h0f);

        #12;
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        chk("rst.valids", 64'({bus.lsu_arvalid, bus.lsu_awvalid, bus.lsu_wvalid, rsp_valid}), 64'd0);
        chk("rst.addr", 64'(bus.lsu_araddr), 64'd0);
        chk("rst.strb", 64'({bus.lsu_rstrb, bus.lsu_wstrb}), 64'd0);
        chk("rst.rsp", 64'({rsp_wen, rsp_rd, rsp_rdata, rsp_err}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vt[i]);

        // Asynchronous reset in the middle of a load.
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_addr   = 32'h80000040;
        req_funct3 = 3'b010;
        req_rd     = 5'd20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("arst.arvalid_before", 64'(bus.lsu_arvalid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst.arvalid_drop", 64'(bus.lsu_arvalid), 64'd0);
        chk("arst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst.req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid || bus.lsu_arvalid) n++;
        end
        chk("arst.no_activity", 64'(n), 64'd0);
        run_vec(mk("lw_after", 0, 32'h80000044, 0, 3'b010, 5'd21, 1, 2,
                   32'hA5A5F00D, 0, 2'b00, 32'hA5A5F00D, 8'h0f));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
